mem_arbiter: RTL



---
 rtl/mem_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch vs. data access sharing one
// memory port. The data side has priority, but a waiting fetch is never starved.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_done,
  input  logic [1:0]  dm_command,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_done,
  output logic [1:0]  mem_command,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        if_stall
);

  localparam logic [1:0]  BUS_NONE  = 2'h0;
  localparam logic [1:0]  BUS_LOAD  = 2'h1;
  localparam logic [31:0] NOOP_INST = 32'h0000_0013;
  localparam logic [3:0]  LIMIT     = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] starve_cnt;
  logic       if_want;
  logic       dm_want;
  logic       can_decide;
  logic       grant_if;
  logic       grant_dm;

  assign if_want = if_req;
  assign dm_want = (dm_command != BUS_NONE);

  // No grant while a done pulse is visible: the requester has not yet had a
  // chance to drop or replace the request it just had serviced.
  assign can_decide = (state == IDLE) && !if_done && !dm_done;
  assign grant_dm   = can_decide && dm_want && (!if_want || (starve_cnt < LIMIT));
  assign grant_if   = can_decide && if_want && (!dm_want || (starve_cnt >= LIMIT));

  assign if_stall = if_req && !if_done;

  // NOTE: every register here uses non-blocking assignment so all state updates
  // see the same pre-edge values, regardless of statement order.
  // NOTE: the data-return registers are reset too, because if_data must come
  // out of reset holding a harmless NOP rather than X.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      starve_cnt  <= 4'd0;
      mem_command <= BUS_NONE;
      mem_addr    <= 32'd0;
      mem_wdata   <= 32'd0;
      if_data     <= NOOP_INST;
      dm_rdata    <= 32'd0;
      if_done     <= 1'b0;
      dm_done     <= 1'b0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_dm) begin
            state       <= DM_BUSY;
            mem_command <= dm_command;
            mem_addr    <= dm_addr;
            mem_wdata   <= dm_wdata;
            if (if_want) begin
              starve_cnt <= (starve_cnt == 4'hF) ? 4'hF : starve_cnt + 4'd1;
            end else begin
              starve_cnt <= 4'd0;
            end
          end else if (grant_if) begin
            state       <= IF_BUSY;
            mem_command <= BUS_LOAD;
            mem_addr    <= if_addr;
            starve_cnt  <= 4'd0;
          end
        end
        IF_BUSY: begin
          if (mem_ack) begin
            if_data     <= mem_rdata;
            if_done     <= 1'b1;
            mem_command <= BUS_NONE;
            state       <= IDLE;
          end
        end
        DM_BUSY: begin
          if (mem_ack) begin
            // Stores complete without disturbing the last load result.
            if (mem_command == BUS_LOAD) begin
              dm_rdata <= mem_rdata;
            end
            dm_done     <= 1'b1;
            mem_command <= BUS_NONE;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          mem_command <= BUS_NONE;
        end
      endcase
    end
  end

endmodule
